pcm_stream_player: RTL and testbench
====================================

Name: pcm_stream_player

Overview:
- Parametrised successor to the fixed 2x16-bit UART-to-FIFO audio path.
- Assembles a serial byte stream (from uart_rx) into multi-channel PCM frames and buffers them in an internal FIFO.
- Releases one frame per sample-rate enable pulse, with prefill, underrun recovery, a partial-frame timeout and hysteresis-based flow control.
- Sits between uart_rx / counter_clock_enable and the per-channel fo_sigma_delta_dac instances.

Parameters:
CHANNELS, 2, number of interleaved channels per frame (1..8)
SAMPLE_BITS, 16, bits per sample; multiple of 8, 8..24
DEPTH, 1024, FIFO depth in frames; power of 2
START_LEVEL, 256, fill required before playback starts or restarts
HIGH_MARK, 768, fill at or above which flow_ready deasserts
LOW_MARK, 256, fill at or below which flow_ready reasserts; must be < HIGH_MARK
TIMEOUT_CYCLES, 48, idle clk cycles that discard a partial frame; 0 disables the timeout
SIGNED, 1, 1: mute value is 0; 0: mute value is midscale (1<<(SAMPLE_BITS-1))
UNDERRUN_HOLD, 0, 0: output mute value on underrun; 1: hold the last sample

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
sample_tick  in  1  one-cycle sample-rate enable
sample_out  out  CHANNELS*SAMPLE_BITS  current frame; channel 0 in the MSB slice
playing  out  1  high while in state PLAYING
fill  out  clog2(DEPTH)+1  frames currently stored
flow_ready  out  1  high = sender may transmit (drives CTS)
underrun_count  out  16  saturating count of underruns
overflow_count  out  16  saturating count of frames dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): all outputs and counters go to their reset values.
  - sample_out = mute value on every channel.
  - playing = 0, fill = 0, flow_ready = 1, both counters = 0.
  - byte index = 0, FSM state = PRIMING.
- Byte assembly:
  - BPS = SAMPLE_BITS/8; BPF = CHANNELS*BPS.
  - Byte index k (0..BPF-1) advances on each rx_valid.
  - Byte k goes to channel c = k/BPS, byte b = k%BPS, at frame bits [(CHANNELS-1-c)*SAMPLE_BITS + 8b +: 8]. Samples are little-endian; channels are sent in order 0..CHANNELS-1.
  - On byte BPF-1 the index wraps to 0 and the frame is written. fill increments in the following cycle.
- Overflow: a frame completed while fill == DEPTH is dropped and overflow_count increments, saturating at 0xFFFF. The FIFO contents are unchanged.
- Timeout:
  - The idle counter clears on each rx_valid.
  - If index != 0 and the idle counter reaches TIMEOUT_CYCLES, the index returns to 0 and the partial frame is discarded. This is not counted as an overflow.
  - The counter does not run while index == 0.
- FIFO:
  - Synchronous RAM with a registered read. Pointers wrap modulo DEPTH.
  - A simultaneous write and pop in the same cycle leaves fill unchanged.
  - No write-to-read bypass: a pop when fill == 0 is an underrun, even if a write occurs in the same cycle.
- Player FSM:
  - PRIMING, on sample_tick:
    - If fill >= START_LEVEL: pop and go to PLAYING.
    - Otherwise stay. sample_out stays at the mute value, or at the last sample if UNDERRUN_HOLD=1.
  - PLAYING, on sample_tick:
    - If fill > 0: pop.
    - If fill == 0: underrun. underrun_count increments (saturating); go to PRIMING; sample_out becomes the mute value (or holds if UNDERRUN_HOLD=1) 2 cycles after the tick.
  - Timing for a pop:
    - fill decrements 1 cycle after the tick.
    - playing rises 1 cycle after the tick.
    - sample_out updates exactly 2 cycles after the tick.
  - Ticks on consecutive cycles are legal; each one pops.
- Flow control:
  - flow_ready drops when fill >= HIGH_MARK.
  - It rises when fill <= LOW_MARK.
  - Between the marks it holds its previous value.
  - It is evaluated from registered fill, so it changes 1 cycle after fill crosses a mark.
- Reset mid-frame or mid-playback discards everything; there is no output glitch beyond the jump to the mute value.

Test Plan:
- Defaults; send bytes 34 12 78 56 -> 1 cycle after the 4th rx_valid, fill = 1. After priming, sample_out = 0x12345678 (ch0 = 0x1234, ch1 = 0x5678).
- Send 255 frames, then 1000 sample_tick pulses -> playing stays 0 and sample_out = 0. Send the 256th frame, then a tick -> playing = 1 next cycle, first frame on sample_out 2 cycles after the tick.
- While playing, stop input and tick until fill reaches 0; one further tick -> underrun_count = 1, playing = 0, sample_out = 0. Repeat with SIGNED=0 -> sample_out = 0x80008000. Repeat with UNDERRUN_HOLD=1 -> last frame is held.
- Send 3 bytes, then idle 48 cycles, then 4 bytes AA BB CC DD -> exactly one frame is stored, with value 0xBBAADDCC.
- Fill to 1024 and send 3 more frames -> overflow_count = 3, fill = 1024. flow_ready fell 1 cycle after fill reached 768; it rises only after draining to fill = 256.
- CHANNELS=4, SAMPLE_BITS=24; 12 bytes 01..0C -> frame = 0x030201_060504_090807_0C0B0A. Assert reset_n mid-frame -> fill = 0 and all outputs at reset values immediately.

Source files
------------

// File: rtl/pcm_stream_player.sv
// pcm_stream_player
//   Assembles a byte stream into multi-channel PCM frames, buffers them in a
//   FIFO and releases one frame per sample_tick. Playback waits for a prefill
//   level, drops back to priming on underrun, discards stale partial frames
//   after an idle timeout and drives a hysteresis flow-control signal.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   rx_data        received byte
//   rx_valid       one-cycle strobe qualifying rx_data
//   sample_tick    one-cycle sample-rate enable
//   sample_out     current frame, channel 0 in the MSB slice
//   playing        high while the player is in PLAYING
//   fill           frames currently stored
//   flow_ready     high when the sender may transmit
//   underrun_count saturating underrun counter
//   overflow_count saturating count of frames dropped on a full FIFO
//
// Player states
//   state   | meaning
//   PRIMING | waiting for fill >= START_LEVEL before popping
//   PLAYING | popping one frame per sample_tick
module pcm_stream_player #(
  parameter int CHANNELS       = 2,
  parameter int SAMPLE_BITS    = 16,
  parameter int DEPTH          = 1024,
  parameter int START_LEVEL    = 256,
  parameter int HIGH_MARK      = 768,
  parameter int LOW_MARK       = 256,
  parameter int TIMEOUT_CYCLES = 48,
  parameter int SIGNED         = 1,
  parameter int UNDERRUN_HOLD  = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  input  logic                            sample_tick,
  output logic [CHANNELS*SAMPLE_BITS-1:0] sample_out,
  output logic                            playing,
  output logic [$clog2(DEPTH):0]          fill,
  output logic                            flow_ready,
  output logic [15:0]                     underrun_count,
  output logic [15:0]                     overflow_count
);

  localparam int FW     = CHANNELS * SAMPLE_BITS;
  localparam int BPS    = SAMPLE_BITS / 8;
  localparam int BPF    = CHANNELS * BPS;
  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam int IDX_W  = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BPF - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] START_LVL = FILL_W'(START_LEVEL);
  localparam logic [FILL_W-1:0] HIGH_LVL  = FILL_W'(HIGH_MARK);
  localparam logic [FILL_W-1:0] LOW_LVL   = FILL_W'(LOW_MARK);

  localparam logic [SAMPLE_BITS-1:0] MUTE_SAMPLE =
    (SIGNED != 0) ? '0 : {1'b1, {(SAMPLE_BITS-1){1'b0}}};
  localparam logic [FW-1:0] MUTE_FRAME = {CHANNELS{MUTE_SAMPLE}};

  typedef enum logic {PRIMING, PLAYING} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  byte_idx;
  logic [TO_W-1:0]   idle_cnt;
  logic [FW-1:0]     asm_frame, frame_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     mem [DEPTH];
  logic [FW-1:0]     rd_data;
  logic              frame_done, fifo_full, wr_en, pop, underrun;
  logic              pop_d, underrun_d;

  // Merge the incoming byte into the frame being assembled; the merged value
  // is what gets written when the last byte arrives.
  always_comb begin
    frame_next = asm_frame;
    for (int k = 0; k < BPF; k++) begin
      if (rx_valid && byte_idx == IDX_W'(k))
        frame_next[(CHANNELS-1-k/BPS)*SAMPLE_BITS + 8*(k%BPS) +: 8] = rx_data;
    end
  end

  assign frame_done = rx_valid && (byte_idx == IDX_LAST);
  assign fifo_full  = (fill == FULL_LVL);
  assign wr_en      = frame_done && !fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx  <= '0;
      idle_cnt  <= '0;
      asm_frame <= '0;
    end else begin
      asm_frame <= frame_next;
      if (rx_valid) begin
        idle_cnt <= '0;
        byte_idx <= frame_done ? '0 : byte_idx + IDX_W'(1);
      end else if (TIMEOUT_CYCLES != 0 && byte_idx != '0) begin
        // A stalled sender leaves a partial frame; drop it so the next byte
        // realigns to channel 0.
        if (idle_cnt == TO_LAST) begin
          byte_idx <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= frame_next;
    if (pop)   rd_data     <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= PRIMING;
    else          state_q <= state_d;
  end

  // Pops only see registered fill, so a frame written in the tick cycle
  // cannot rescue an empty FIFO.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    underrun = 1'b0;
    if (sample_tick) begin
      case (state_q)
        PRIMING: begin
          if (fill >= START_LVL && fill != '0) begin
            pop     = 1'b1;
            state_d = PLAYING;
          end
        end
        PLAYING: begin
          if (fill != '0) begin
            pop = 1'b1;
          end else begin
            underrun = 1'b1;
            state_d  = PRIMING;
          end
        end
        default: state_d = PRIMING;
      endcase
    end
  end

  assign playing = (state_q == PLAYING);

  // Output lags the tick by two cycles: one for the RAM read, one here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_d          <= 1'b0;
      underrun_d     <= 1'b0;
      sample_out     <= MUTE_FRAME;
      underrun_count <= '0;
      overflow_count <= '0;
      flow_ready     <= 1'b1;
    end else begin
      pop_d      <= pop;
      underrun_d <= underrun;
      if (pop_d)
        sample_out <= rd_data;
      else if (underrun_d && UNDERRUN_HOLD == 0)
        sample_out <= MUTE_FRAME;
      if (underrun && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;
      if (frame_done && fifo_full && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
      if (fill >= HIGH_LVL)
        flow_ready <= 1'b0;
      else if (fill <= LOW_LVL)
        flow_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_stream_player.sv
// tb_pcm_stream_player
//   Bench for pcm_stream_player. Instance dut_a uses the default parameters
//   and is tracked every cycle by a queue-based reference model; instance
//   dut_b (4 x 24-bit, offset-binary mute, hold on underrun, tiny FIFO) is
//   exercised from a vector table plus short directed sequences.
module tb_pcm_stream_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A (defaults) ----------------
  logic        a_rst_n, a_rx_valid, a_tick;
  logic [7:0]  a_rx_data;
  logic [31:0] a_out;
  logic        a_playing, a_flow;
  logic [10:0] a_fill;
  logic [15:0] a_und, a_ovf;

  pcm_stream_player dut_a (
    .clk(clk), .reset_n(a_rst_n), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .sample_tick(a_tick), .sample_out(a_out), .playing(a_playing), .fill(a_fill),
    .flow_ready(a_flow), .underrun_count(a_und), .overflow_count(a_ovf)
  );

  // ---------------- DUT B ----------------
  logic        b_rst_n, b_rx_valid, b_tick;
  logic [7:0]  b_rx_data;
  logic [95:0] b_out;
  logic        b_playing, b_flow;
  logic [3:0]  b_fill;
  logic [15:0] b_und, b_ovf;

  pcm_stream_player #(
    .CHANNELS(4), .SAMPLE_BITS(24), .DEPTH(8), .START_LEVEL(1), .HIGH_MARK(6),
    .LOW_MARK(2), .TIMEOUT_CYCLES(8), .SIGNED(0), .UNDERRUN_HOLD(1)
  ) dut_b (
    .clk(clk), .reset_n(b_rst_n), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .sample_tick(b_tick), .sample_out(b_out), .playing(b_playing), .fill(b_fill),
    .flow_ready(b_flow), .underrun_count(b_und), .overflow_count(b_ovf)
  );

  localparam logic [95:0] B_MUTE = {4{24'h800000}};

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model for DUT A ----------------
  logic [31:0] mq[$];
  logic [7:0]  m_part[4];
  int          m_nb, m_idle, m_und, m_ovf;
  bit          m_play, m_flow, m_sv;
  logic [31:0] m_out, m_sval;

  task automatic model_reset();
    mq.delete();
    m_nb = 0; m_idle = 0; m_und = 0; m_ovf = 0;
    m_play = 0; m_flow = 1; m_sv = 0;
    m_out = 32'h0; m_sval = 32'h0;
  endtask

  // One clock edge, using the inputs held before it.
  task automatic model_step();
    int f;
    f = mq.size();
    if (m_sv) m_out = m_sval;
    m_sv = 0;
    if (a_tick && (m_play || f >= 256)) begin
      if (f > 0) begin
        m_sval = mq.pop_front();
        m_sv   = 1;
        m_play = 1;
      end else begin
        m_sval = 32'h0;
        m_sv   = 1;
        m_play = 0;
        if (m_und < 65535) m_und++;
      end
    end
    if (f >= 768)      m_flow = 0;
    else if (f <= 256) m_flow = 1;
    if (a_rx_valid) begin
      m_part[m_nb] = a_rx_data;
      m_nb++;
      m_idle = 0;
      if (m_nb == 4) begin
        if (f == 1024) begin
          if (m_ovf < 65535) m_ovf++;
        end else begin
          mq.push_back({m_part[1], m_part[0], m_part[3], m_part[2]});
        end
        m_nb = 0;
      end
    end else if (m_nb != 0) begin
      m_idle++;
      if (m_idle == 48) begin
        m_nb = 0;
        m_idle = 0;
      end
    end
  endtask

  task automatic model_check();
    chk("a_sample_out", 96'(a_out), 96'(m_out));
    chk("a_fill", 96'(a_fill), 96'(mq.size()));
    chk("a_playing", 96'(a_playing), 96'(m_play));
    chk("a_flow_ready", 96'(a_flow), 96'(m_flow));
    chk("a_underrun_count", 96'(a_und), 96'(m_und));
    chk("a_overflow_count", 96'(a_ovf), 96'(m_ovf));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (a_rst_n) model_step();
    #1;
    if (a_rst_n) model_check();
  endtask

  task automatic a_byte(input logic [7:0] d);
    a_rx_valid = 1'b1;
    a_rx_data  = d;
    cyc();
    a_rx_valid = 1'b0;
  endtask

  // Frame value ch0 in the upper half; each sample is sent little-endian.
  task automatic a_frame(input logic [31:0] s);
    a_byte(s[23:16]);
    a_byte(s[31:24]);
    a_byte(s[7:0]);
    a_byte(s[15:8]);
  endtask

  task automatic b_send(input logic [95:0] bytes_in, input int n);
    for (int k = 0; k < n; k++) begin
      b_rx_valid = 1'b1;
      b_rx_data  = bytes_in[95-8*k -: 8];
      cyc();
    end
    b_rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [95:0] bytes_in;   // byte 0 in the MSBs, in send order
    logic [95:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time %0t exceeded limit 3ms", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int guard;

    tbl[0].bytes_in = 96'h0102030405060708090A0B0C;
    tbl[0].exp      = 96'h030201_060504_090807_0C0B0A;
    tbl[1].bytes_in = 96'h102030405060708090A0B0C0;
    tbl[1].exp      = 96'h302010_605040_908070_C0B0A0;
    tbl[2].bytes_in = 96'hFFFFFFFFFFFFFFFFFFFFFF00;
    tbl[2].exp      = 96'hFFFFFF_FFFFFF_FFFFFF_00FFFF;
    tbl[3].bytes_in = 96'hA1B2C3D4E5F60718293A4B5C;
    tbl[3].exp      = 96'hC3B2A1_F6E5D4_291807_5C4B3A;

    a_rst_n = 1'b0; a_rx_valid = 1'b0; a_rx_data = 8'h0; a_tick = 1'b0;
    b_rst_n = 1'b0; b_rx_valid = 1'b0; b_rx_data = 8'h0; b_tick = 1'b0;
    model_reset();
    repeat (3) cyc();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    chk("a_reset_out", 96'(a_out), 96'h0);
    chk("a_reset_playing", 96'(a_playing), 96'h0);
    chk("a_reset_fill", 96'(a_fill), 96'h0);
    chk("a_reset_flow", 96'(a_flow), 96'h1);
    chk("a_reset_und", 96'(a_und), 96'h0);
    chk("a_reset_ovf", 96'(a_ovf), 96'h0);

    // First frame: fill visible one cycle after the 4th byte.
    a_frame(32'h12345678);
    chk("a_first_frame_fill", 96'(a_fill), 96'd1);

    // Partial frame discarded after 48 idle cycles.
    a_byte(8'h11); a_byte(8'h22); a_byte(8'h33);
    repeat (48) cyc();
    a_frame(32'hBBAADDCC);
    chk("a_timeout_fill", 96'(a_fill), 96'd2);

    // 47 idle cycles keep the partial frame.
    a_byte(8'h01);
    repeat (47) cyc();
    a_byte(8'h02); a_byte(8'h03); a_byte(8'h04);
    chk("a_no_timeout_fill", 96'(a_fill), 96'd3);

    repeat (252) a_frame($urandom);
    chk("a_prefill_255", 96'(a_fill), 96'd255);
    a_tick = 1'b1;
    repeat (1000) cyc();
    a_tick = 1'b0;
    chk("a_priming_playing", 96'(a_playing), 96'h0);
    chk("a_priming_out", 96'(a_out), 96'h0);

    a_frame($urandom);
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    chk("a_start_playing", 96'(a_playing), 96'h1);
    chk("a_start_fill", 96'(a_fill), 96'd255);
    cyc();
    chk("a_first_sample", 96'(a_out), 96'h12345678);
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    cyc();
    chk("a_second_sample", 96'(a_out), 96'hBBAADDCC);

    // Drain, then one more tick underruns.
    guard = 0;
    while (a_fill != 11'd0 && guard < 2000) begin
      a_tick = 1'b1;
      cyc();
      guard++;
    end
    a_tick = 1'b0;
    chk("a_drain_fill", 96'(a_fill), 96'h0);
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    chk("a_underrun_playing", 96'(a_playing), 96'h0);
    cyc();
    chk("a_underrun_out", 96'(a_out), 96'h0);
    chk("a_underrun_count", 96'(a_und), 96'd1);

    // Fill to full with flow-control timing, then overflow.
    for (int i = 0; i < 1024; i++) begin
      a_frame($urandom);
      if (i == 767) begin
        chk("a_flow_at_768", 96'(a_flow), 96'h1);
        cyc();
        chk("a_flow_after_768", 96'(a_flow), 96'h0);
      end
    end
    repeat (3) a_frame($urandom);
    chk("a_ovf_count", 96'(a_ovf), 96'd3);
    chk("a_ovf_fill", 96'(a_fill), 96'd1024);
    chk("a_ovf_flow", 96'(a_flow), 96'h0);
    a_tick = 1'b1;
    repeat (768) cyc();
    a_tick = 1'b0;
    chk("a_low_fill", 96'(a_fill), 96'd256);
    chk("a_low_flow_hold", 96'(a_flow), 96'h0);
    cyc();
    chk("a_low_flow_rise", 96'(a_flow), 96'h1);

    // Randomised traffic: first build up, then drain hard enough to underrun.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        a_rx_valid = 1'b0;
        a_tick     = 1'b0;
        repeat ($urandom_range(40, 56)) cyc();
      end
      a_rx_valid = ($urandom_range(0, 1) == 1);
      a_rx_data  = 8'($urandom);
      a_tick     = (i < 2000) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      cyc();
    end
    a_rx_valid = 1'b0;
    a_tick     = 1'b0;

    // Asynchronous reset mid-frame.
    a_frame($urandom);
    a_byte(8'h5A); a_byte(8'hA5);
    #2 a_rst_n = 1'b0;
    #1;
    chk("a_async_rst_out", 96'(a_out), 96'h0);
    chk("a_async_rst_fill", 96'(a_fill), 96'h0);
    chk("a_async_rst_playing", 96'(a_playing), 96'h0);
    chk("a_async_rst_flow", 96'(a_flow), 96'h1);
    chk("a_async_rst_und", 96'(a_und), 96'h0);
    chk("a_async_rst_ovf", 96'(a_ovf), 96'h0);
    model_reset();
    cyc(); cyc();
    a_rst_n = 1'b1;
    a_frame(32'hCAFEF00D);
    chk("a_post_rst_fill", 96'(a_fill), 96'd1);

    // ---------------- DUT B ----------------
    chk("b_reset_out", b_out, B_MUTE);
    chk("b_reset_fill", 96'(b_fill), 96'h0);
    chk("b_reset_flow", 96'(b_flow), 96'h1);
    chk("b_reset_playing", 96'(b_playing), 96'h0);

    for (int v = 0; v < 4; v++) begin
      b_send(tbl[v].bytes_in, 12);
      chk("b_vec_fill", 96'(b_fill), 96'd1);
      b_tick = 1'b1; cyc(); b_tick = 1'b0;
      chk("b_vec_playing", 96'(b_playing), 96'h1);
      chk("b_vec_fill_pop", 96'(b_fill), 96'h0);
      cyc();
      chk("b_vec_frame", b_out, tbl[v].exp);
    end

    b_tick = 1'b1; cyc(); b_tick = 1'b0;
    chk("b_underrun_playing", 96'(b_playing), 96'h0);
    cyc();
    chk("b_underrun_hold", b_out, tbl[3].exp);
    chk("b_underrun_count", 96'(b_und), 96'd1);

    b_send(tbl[1].bytes_in, 5);
    repeat (8) cyc();
    b_send(tbl[0].bytes_in, 12);
    chk("b_timeout_fill", 96'(b_fill), 96'd1);
    b_tick = 1'b1; cyc(); b_tick = 1'b0;
    cyc();
    chk("b_timeout_frame", b_out, tbl[0].exp);

    b_send(tbl[2].bytes_in, 12);
    b_send(tbl[1].bytes_in, 5);
    #2 b_rst_n = 1'b0;
    #1;
    chk("b_async_rst_out", b_out, B_MUTE);
    chk("b_async_rst_fill", 96'(b_fill), 96'h0);
    chk("b_async_rst_playing", 96'(b_playing), 96'h0);
    chk("b_async_rst_und", 96'(b_und), 96'h0);
    cyc();
    b_rst_n = 1'b1;

    repeat (10) b_send(tbl[1].bytes_in, 12);
    chk("b_ovf_fill", 96'(b_fill), 96'd8);
    chk("b_ovf_count", 96'(b_ovf), 96'd2);
    chk("b_ovf_flow", 96'(b_flow), 96'h0);
    b_tick = 1'b1; cyc(); b_tick = 1'b0;
    cyc();
    chk("b_after_ovf_frame", b_out, tbl[1].exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
